// File: rtl/conv_param_mem.sv
// Parameter store for the 1D convolution datapath: three weight banks plus a bias bank,
// with a manual config port and a per-filter stream toward the multipliers and bias adder.
module conv_param_mem #(
    parameter  int BW          = 8,
    parameter  int BIAS_BW     = 32,
    parameter  int FRAME_LEN   = 50,
    parameter  int COLUMN_LEN  = 13,
    parameter  int NUM_FILTERS = 8,
    localparam int VECTOR_BW   = COLUMN_LEN * BW,
    localparam int ADDR_BW     = $clog2(NUM_FILTERS),
    localparam int BANK_BW     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 cycle_en_i,
    input  logic                 rd_en_i,
    input  logic                 wr_en_i,
    input  logic [BANK_BW-1:0]   rd_wr_bank_i,
    input  logic [ADDR_BW-1:0]   rd_wr_addr_i,
    input  logic [VECTOR_BW-1:0] wr_data_i,
    output logic [VECTOR_BW-1:0] rd_data_o,
    output logic [VECTOR_BW-1:0] data0_o,
    output logic [VECTOR_BW-1:0] data1_o,
    output logic [VECTOR_BW-1:0] data2_o,
    output logic [BIAS_BW-1:0]   bias_o,
    output logic                 valid_o,
    output logic                 last_o,
    input  logic                 ready_i
);

    localparam int POS_BW = $clog2(FRAME_LEN);
    localparam logic [ADDR_BW-1:0] LAST_FILT = ADDR_BW'(NUM_FILTERS - 1);
    localparam logic [POS_BW-1:0]  LAST_POS  = POS_BW'(FRAME_LEN - 1);

    typedef enum logic [BANK_BW-1:0] {
        BANK_W0   = 2'd0,
        BANK_W1   = 2'd1,
        BANK_W2   = 2'd2,
        BANK_BIAS = 2'd3
    } bank_e;

    logic [VECTOR_BW-1:0] w0_mem   [NUM_FILTERS];
    logic [VECTOR_BW-1:0] w1_mem   [NUM_FILTERS];
    logic [VECTOR_BW-1:0] w2_mem   [NUM_FILTERS];
    logic [BIAS_BW-1:0]   bias_mem [NUM_FILTERS];

    logic                 addr_ok;
    logic [VECTOR_BW-1:0] rd_word;
    logic [VECTOR_BW-1:0] rd_data_q;

    logic [ADDR_BW-1:0]   filt_q, filt_d;
    logic [POS_BW-1:0]    pos_q, pos_d;
    logic                 advance;
    logic [VECTOR_BW-1:0] data0_q, data1_q, data2_q;
    logic [BIAS_BW-1:0]   bias_q;
    logic                 valid_q, last_q;

    // A power-of-two bank depth makes every address legal; otherwise range-check it.
    if (NUM_FILTERS == (1 << ADDR_BW)) begin : g_addr_full
        assign addr_ok = 1'b1;
    end else begin : g_addr_part
        assign addr_ok = (int'(rd_wr_addr_i) < NUM_FILTERS);
    end

    // NOTE: storage has no reset branch so it maps onto plain RAM/flop arrays;
    // contents stay undefined until the config port writes them.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && addr_ok) begin
            case (bank_e'(rd_wr_bank_i))
                BANK_W0:   w0_mem[rd_wr_addr_i]   <= wr_data_i;
                BANK_W1:   w1_mem[rd_wr_addr_i]   <= wr_data_i;
                BANK_W2:   w2_mem[rd_wr_addr_i]   <= wr_data_i;
                BANK_BIAS: bias_mem[rd_wr_addr_i] <= wr_data_i[BIAS_BW-1:0];
                default:   ;
            endcase
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        rd_word = '0;
        if (addr_ok) begin
            case (bank_e'(rd_wr_bank_i))
                BANK_W0:   rd_word = w0_mem[rd_wr_addr_i];
                BANK_W1:   rd_word = w1_mem[rd_wr_addr_i];
                BANK_W2:   rd_word = w2_mem[rd_wr_addr_i];
                BANK_BIAS: rd_word = VECTOR_BW'(bias_mem[rd_wr_addr_i]);
                default:   rd_word = '0;
            endcase
        end
    end

    // NOTE: non-blocking assignments make a same-cycle read see the pre-write contents.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_word;
        end
    end

    // A beat is taken when requested and the output stage is empty or being drained.
    assign advance = cycle_en_i && (!valid_q || ready_i);

    always_comb begin
        filt_d = filt_q;
        pos_d  = pos_q;
        if (advance) begin
            if (filt_q == LAST_FILT) begin
                filt_d = '0;
                pos_d  = (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;
            end else begin
                filt_d = filt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            filt_q  <= '0;
            pos_q   <= '0;
            data0_q <= '0;
            data1_q <= '0;
            data2_q <= '0;
            bias_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            filt_q <= filt_d;
            pos_q  <= pos_d;
            if (advance) begin
                data0_q <= w0_mem[filt_q];
                data1_q <= w1_mem[filt_q];
                data2_q <= w2_mem[filt_q];
                bias_q  <= bias_mem[filt_q];
                valid_q <= 1'b1;
                last_q  <= (filt_q == LAST_FILT) && (pos_q == LAST_POS);
            end else if (!valid_q || ready_i) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign rd_data_o = rd_data_q;
    assign data0_o   = data0_q;
    assign data1_o   = data1_q;
    assign data2_o   = data2_q;
    assign bias_o    = bias_q;
    assign valid_o   = valid_q;
    assign last_o    = last_q;

endmodule

// File: tb/tb_conv_param_mem.sv
// Self-checking bench for conv_param_mem: directed scenarios plus random traffic,
// compared every cycle against a beat-count based reference model.
module tb_conv_param_mem;

    localparam int NF  = 8;
    localparam int FL  = 50;
    localparam int COL = 13;
    localparam int VBW = COL * 8;
    localparam int BBW = 32;
    localparam int BEATS_PER_FRAME = NF * FL;

    logic           clk_i        = 1'b0;
    logic           rst_n_i      = 1'b0;
    logic           cycle_en_i   = 1'b0;
    logic           rd_en_i      = 1'b0;
    logic           wr_en_i      = 1'b0;
    logic [1:0]     rd_wr_bank_i = '0;
    logic [2:0]     rd_wr_addr_i = '0;
    logic [VBW-1:0] wr_data_i    = '0;
    logic           ready_i      = 1'b0;
    logic [VBW-1:0] rd_data_o, data0_o, data1_o, data2_o;
    logic [BBW-1:0] bias_o;
    logic           valid_o, last_o;

    conv_param_mem dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .cycle_en_i   (cycle_en_i),
        .rd_en_i      (rd_en_i),
        .wr_en_i      (wr_en_i),
        .rd_wr_bank_i (rd_wr_bank_i),
        .rd_wr_addr_i (rd_wr_addr_i),
        .wr_data_i    (wr_data_i),
        .rd_data_o    (rd_data_o),
        .data0_o      (data0_o),
        .data1_o      (data1_o),
        .data2_o      (data2_o),
        .bias_o       (bias_o),
        .valid_o      (valid_o),
        .last_o       (last_o),
        .ready_i      (ready_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [VBW-1:0] act, input logic [VBW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: memory arrays plus a count of beats accepted since reset.
    logic [VBW-1:0] m_w [3][NF];
    logic [BBW-1:0] m_b [NF];
    int             m_k;
    bit             m_valid, m_last;
    logic [VBW-1:0] m_d0, m_d1, m_d2, m_rd;
    logic [BBW-1:0] m_bias;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_k = 0; m_valid = 0; m_last = 0;
            m_d0 = '0; m_d1 = '0; m_d2 = '0; m_bias = '0; m_rd = '0;
        end else begin
            int f, p, b, a;
            b = int'(rd_wr_bank_i);
            a = int'(rd_wr_addr_i);
            if (rd_en_i) m_rd = (a >= NF) ? '0 : (b == 3) ? VBW'(m_b[a]) : m_w[b][a];
            if (cycle_en_i && (!m_valid || ready_i)) begin
                f = m_k % NF;
                p = (m_k / NF) % FL;
                m_d0 = m_w[0][f]; m_d1 = m_w[1][f]; m_d2 = m_w[2][f]; m_bias = m_b[f];
                m_valid = 1;
                m_last  = (f == NF - 1) && (p == FL - 1);
                m_k++;
            end else if (!m_valid || ready_i) begin
                m_valid = 0;
                m_last  = 0;
            end
            if (wr_en_i && a < NF) begin
                if (b == 3) m_b[a] = wr_data_i[BBW-1:0];
                else        m_w[b][a] = wr_data_i;
            end
        end
    end

    always @(posedge clk_i) begin
        #1;
        if (cmp_en && rst_n_i) begin
            check("valid",   VBW'(valid_o), VBW'(m_valid));
            check("last",    VBW'(last_o),  VBW'(m_last));
            check("data0",   data0_o,       m_d0);
            check("data1",   data1_o,       m_d1);
            check("data2",   data2_o,       m_d2);
            check("bias",    VBW'(bias_o),  VBW'(m_bias));
            check("rd_data", rd_data_o,     m_rd);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [VBW-1:0] pat(input int b, input int a);
        logic [7:0] v;
        v = 8'(8'hA0 + 8 * b + a);
        return {COL{v}};
    endfunction

    // Tasks start and end on a falling edge; inputs are held for one full cycle.
    task automatic write_word(input int b, input int a, input logic [VBW-1:0] d);
        wr_en_i = 1'b1; rd_wr_bank_i = 2'(b); rd_wr_addr_i = 3'(a); wr_data_i = d;
        @(negedge clk_i);
        wr_en_i = 1'b0;
    endtask

    task automatic read_word(input int b, input int a);
        rd_en_i = 1'b1; rd_wr_bank_i = 2'(b); rd_wr_addr_i = 3'(a);
        @(negedge clk_i);
        rd_en_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, VBW'(valid_o), '0);
        check({tag, "_last"},  VBW'(last_o),  '0);
        check({tag, "_data0"}, data0_o,       '0);
        check({tag, "_data1"}, data1_o,       '0);
        check({tag, "_data2"}, data2_o,       '0);
        check({tag, "_bias"},  VBW'(bias_o),  '0);
        check({tag, "_rd"},    rd_data_o,     '0);
    endtask

    initial begin
        bit found;
        logic [127:0] rnd;

        repeat (2) @(negedge clk_i);
        check_all_zero("reset");
        rst_n_i = 1'b1;
        cmp_en  = 1'b1;

        // Fill every bank with its pattern, then read everything back.
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < NF; a++)
                write_word(b, a, pat(b, a));
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < NF; a++)
                read_word(b, a);
        read_word(1, 2);
        check("rd_w1_a2", rd_data_o, {COL{8'hAA}});
        read_word(3, 5);
        check("rd_bias5", rd_data_o, VBW'(32'hBDBDBDBD));

        // Same-cycle read and write of one entry returns the old contents.
        write_word(1, 2, {COL{8'h11}});
        rd_en_i = 1'b1; wr_en_i = 1'b1; rd_wr_bank_i = 2'd1; rd_wr_addr_i = 3'd2;
        wr_data_i = {COL{8'h22}};
        @(negedge clk_i);
        rd_en_i = 1'b0; wr_en_i = 1'b0;
        check("rw_old", rd_data_o, {COL{8'h11}});
        read_word(1, 2);
        check("rw_new", rd_data_o, {COL{8'h22}});
        write_word(1, 2, pat(1, 2));

        // Continuous streaming of two full filter sweeps.
        check("pre_valid", VBW'(valid_o), '0);
        cycle_en_i = 1'b1; ready_i = 1'b1;
        for (int i = 0; i < 2 * NF; i++) begin
            @(negedge clk_i);
            if (i == 0) begin
                check("beat0_valid", VBW'(valid_o), VBW'(1'b1));
                check("beat0_data0", data0_o, {COL{8'hA0}});
                check("beat0_bias",  VBW'(bias_o), VBW'(32'hB8B8B8B8));
            end
            if (i == 9) check("beat9_data2", data2_o, {COL{8'hB1}});
        end

        // Three-cycle backpressure with the request held.
        ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            check("stall_data0", data0_o, {COL{8'hA7}});
            check("stall_valid", VBW'(valid_o), VBW'(1'b1));
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        check("resume_data0", data0_o, {COL{8'hA0}});
        check("resume_bias",  VBW'(bias_o), VBW'(32'hB8B8B8B8));

        // Random mix of streaming, backpressure, reads and writes.
        for (int i = 0; i < 600; i++) begin
            cycle_en_i   = ($urandom_range(0, 3) != 0);
            ready_i      = ($urandom_range(0, 3) != 0);
            rd_en_i      = ($urandom_range(0, 2) == 0);
            wr_en_i      = ($urandom_range(0, 3) == 0);
            rd_wr_bank_i = 2'($urandom_range(0, 3));
            rd_wr_addr_i = 3'($urandom_range(0, NF - 1));
            rnd          = {$urandom(), $urandom(), $urandom(), $urandom()};
            wr_data_i    = rnd[VBW-1:0];
            @(negedge clk_i);
        end
        rd_en_i = 1'b0; wr_en_i = 1'b0;

        // Run until filter 5 of position 10 is on the outputs, then reset asynchronously.
        cycle_en_i = 1'b1; ready_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk_i);
            if (m_k % BEATS_PER_FRAME == 5 * 1 + 10 * NF + 1) found = 1'b1;
        end
        check("reach_f5_p10", VBW'(found), VBW'(1'b1));
        #2;
        rst_n_i = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // A full frame after reset: last only on beat 400, beat 401 restarts.
        for (int i = 1; i <= BEATS_PER_FRAME + 1; i++) begin
            @(negedge clk_i);
            if (i == 1)                   check("post_rst_valid", VBW'(valid_o), VBW'(1'b1));
            if (i == BEATS_PER_FRAME - 1) check("last_pre",  VBW'(last_o), '0);
            if (i == BEATS_PER_FRAME)     check("last_beat", VBW'(last_o), VBW'(1'b1));
            if (i == BEATS_PER_FRAME + 1) check("last_wrap", VBW'(last_o), '0);
        end
        cycle_en_i = 1'b0;
        repeat (2) @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
